// File: rtl/sine_pkg.sv
// Shared defaults, quadrant encoding and the quarter-wave table generator for sine_wave_gen.
package sine_pkg;

  localparam int PHASE_W_DEF    = 16;
  localparam int LUT_ADDR_W_DEF = 6;
  localparam int OUT_W_DEF      = 10;

  localparam logic [OUT_W_DEF-1:0] MIDSCALE = 10'h200;

  // Top two phase bits: bit 0 selects the mirrored half, bit 1 the negative half-wave.
  typedef enum logic [1:0] {
    QUAD_RISE     = 2'b00,
    QUAD_FALL     = 2'b01,
    QUAD_NEG_RISE = 2'b10,
    QUAD_NEG_FALL = 2'b11
  } quad_e;

  // round((2^mag_w - 1) * sin(pi*(2i+1)/2^(addr_w+2))) in Q2.30 fixed point, Taylor series.
  function automatic int lut_entry(input int i, input int addr_w, input int mag_w);
    longint x, x2, term, acc, amp;
    x    = (64'sd3373259426 * longint'(2 * i + 1)) >>> (addr_w + 2);
    x2   = (x * x) >>> 30;
    term = x;
    acc  = x;
    for (int k = 1; k <= 8; k++) begin
      term = -(((term * x2) >>> 30) / longint'(2 * k * (2 * k + 1)));
      acc  += term;
    end
    amp = (64'sd1 <<< mag_w) - 64'sd1;
    return int'((amp * acc + (64'sd1 <<< 29)) >>> 30);
  endfunction

endpackage

// File: rtl/sine_lut_quarter.sv
// Registered quarter-wave sine magnitude ROM, one-cycle read latency, read enabled by en.
module sine_lut_quarter
  import sine_pkg::*;
#(
  parameter int ADDR_W = LUT_ADDR_W_DEF,
  parameter int MAG_W  = OUT_W_DEF - 1
) (
  input  logic              Clk,
  input  logic              ResetN,
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  output logic [MAG_W-1:0]  mag
);

  logic [MAG_W-1:0] rom [2**ADDR_W];

  for (genvar g = 0; g < 2**ADDR_W; g++) begin : g_rom
    localparam logic [MAG_W-1:0] ENTRY = MAG_W'(lut_entry(g, ADDR_W, MAG_W));
    assign rom[g] = ENTRY;
  end

  // NOTE: the table is constant and never reset; only the read register carries state.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      mag <= '0;
    end else if (en) begin
      mag <= rom[addr];
    end
  end

endmodule

// File: rtl/sine_wave_gen.sv
// DDS sine generator: phase accumulator, folded quarter-wave LUT, 3-stage pipeline, sticky wrap IRQ.
// Optional: define SINE_PHASE_RESTART_EN to restart the phase from {0,fcw} on every run rising edge.
module sine_wave_gen
  import sine_pkg::*;
#(
  parameter int PHASE_W    = PHASE_W_DEF,
  parameter int LUT_ADDR_W = LUT_ADDR_W_DEF,
  parameter int OUT_W      = OUT_W_DEF
) (
  input  logic             Clk,
  input  logic             ResetN,
  input  logic             run,
  input  logic [7:0]       fcw,
  input  logic             enable_irq,
  input  logic             clear_irq,
  output logic [OUT_W-1:0] data_sin,
  output logic             data_valid,
  output logic             irq
);

  localparam int SUM_W = PHASE_W + 1;
  localparam int MAG_W = OUT_W - 1;
  localparam logic [OUT_W-1:0] MID =
    (OUT_W == OUT_W_DEF) ? OUT_W'(MIDSCALE) : OUT_W'(1) << (OUT_W - 1);
  localparam logic [OUT_W-1:0] MID_M1 = MID - OUT_W'(1);

  logic [PHASE_W-1:0]    phase;
  logic [SUM_W-1:0]      phase_sum;
  logic                  wrap;
  logic [2:0]            valid_sr;
  quad_e                 quad;
  logic [LUT_ADDR_W-1:0] idx;
  logic [LUT_ADDR_W-1:0] lut_addr;
  logic                  neg;
  logic                  neg_d;
  logic [MAG_W-1:0]      mag;
  logic                  pending;

  assign phase_sum = {1'b0, phase} + SUM_W'(fcw);

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      phase <= '0;
      wrap  <= 1'b0;
    end
`ifdef SINE_PHASE_RESTART_EN
    else if (run && !valid_sr[0]) begin
      phase <= PHASE_W'(fcw);
      wrap  <= 1'b0;
    end
`endif
    else if (run) begin
      {wrap, phase} <= phase_sum;
    end else begin
      wrap <= 1'b0;
    end
  end

  // NOTE: defaults are assigned first so every path drives lut_addr and no latch is inferred.
  always_comb begin
    quad     = quad_e'(phase[PHASE_W-1 -: 2]);
    idx      = phase[PHASE_W-3 -: LUT_ADDR_W];
    lut_addr = idx;
    if (quad == QUAD_FALL || quad == QUAD_NEG_FALL) begin
      lut_addr = ~idx;
    end
  end

  assign neg = (quad == QUAD_NEG_RISE) || (quad == QUAD_NEG_FALL);

  sine_lut_quarter #(
    .ADDR_W (LUT_ADDR_W),
    .MAG_W  (MAG_W)
  ) u_lut (
    .Clk    (Clk),
    .ResetN (ResetN),
    .en     (valid_sr[0]),
    .addr   (lut_addr),
    .mag    (mag)
  );

  // Stages 2 and 3 only advance on data from a running phase, so an idle start stays at midscale.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      neg_d    <= 1'b0;
      data_sin <= MID;
      valid_sr <= '0;
    end else begin
      valid_sr <= {valid_sr[1:0], run};
      if (valid_sr[0]) begin
        neg_d <= neg;
      end
      if (valid_sr[1]) begin
        data_sin <= neg_d ? (MID_M1 - OUT_W'(mag)) : (MID + OUT_W'(mag));
      end
    end
  end

  assign data_valid = valid_sr[2];

  // A wrap arriving with a clear strobe wins, so no wrap is lost.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      pending <= 1'b0;
    end else if (wrap && enable_irq) begin
      pending <= 1'b1;
    end else if (clear_irq) begin
      pending <= 1'b0;
    end
  end

  assign irq = pending & enable_irq;

endmodule

// File: tb/tb_sine_wave_gen.sv
// Self-checking bench for sine_wave_gen: phase/sample scoreboard queue plus per-scenario directed checks.
module tb_sine_wave_gen;

  logic       Clk = 1'b0;
  logic       ResetN;
  logic       run;
  logic [7:0] fcw;
  logic       enable_irq;
  logic       clear_irq;
  logic [9:0] data_sin;
  logic       data_valid;
  logic       irq;

  int checks = 0;
  int errors = 0;

  int          bench_lut [64];
  logic [15:0] m_phase;
  logic        m_wrap;
  logic        m_pending;
  logic        m_run_d;
  logic [2:0]  m_vsr;
  int          exp_q [$];
  int          exp_sin;
  logic        exp_valid;
  logic        exp_irq;

  sine_wave_gen dut (
    .Clk        (Clk),
    .ResetN     (ResetN),
    .run        (run),
    .fcw        (fcw),
    .enable_irq (enable_irq),
    .clear_irq  (clear_irq),
    .data_sin   (data_sin),
    .data_valid (data_valid),
    .irq        (irq)
  );

  always #5 Clk = ~Clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int sample_of(input logic [15:0] p);
    int a;
    int mag;
    a = int'(p[13:8]);
    if (p[14]) a = 63 - a;
    mag = bench_lut[a];
    return p[15] ? 511 - mag : 512 + mag;
  endfunction

  task automatic model_reset();
    m_phase   = '0;
    m_wrap    = 1'b0;
    m_pending = 1'b0;
    m_run_d   = 1'b0;
    m_vsr     = '0;
    exp_q.delete();
    exp_sin   = 512;
    exp_valid = 1'b0;
    exp_irq   = 1'b0;
  endtask

  // Model the coming edge from the currently driven inputs, then advance to 1 time unit past it.
  task automatic tick();
    logic [16:0] s;
    logic        pend_next;
    pend_next = (m_wrap && enable_irq) ? 1'b1 : (clear_irq ? 1'b0 : m_pending);
    if (run) begin
      s = {1'b0, m_phase} + {9'd0, fcw};
`ifdef SINE_PHASE_RESTART_EN
      if (!m_run_d) s = {9'd0, fcw};
`endif
      m_phase = s[15:0];
      m_wrap  = s[16];
      exp_q.push_back(sample_of(m_phase));
    end else begin
      m_wrap = 1'b0;
    end
    m_pending = pend_next;
    m_run_d   = run;
    m_vsr     = {m_vsr[1:0], run};
    if (m_vsr[2] && exp_q.size() > 0) exp_sin = exp_q.pop_front();
    exp_valid = m_vsr[2];
    @(posedge Clk);
    #1;
    exp_irq = m_pending & enable_irq;
  endtask

  task automatic test_reset();
    ResetN = 1'b0; run = 1'b0; fcw = 8'h00; enable_irq = 1'b0; clear_irq = 1'b0;
    model_reset();
    #12;
    checks++;
    if (data_sin !== 10'h200 || data_valid !== 1'b0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: got sin=%0d valid=%0b irq=%0b expected 512/0/0", data_sin, data_valid, irq);
    end
    ResetN = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      checks++;
      if (data_sin !== 10'h200 || data_valid !== 1'b0 || irq !== 1'b0) begin
        errors++;
        $display("FAIL idle_after_reset cyc %0d: got sin=%0d valid=%0b irq=%0b expected 512/0/0",
                 i, data_sin, data_valid, irq);
      end
    end
  endtask

  task automatic test_run_wrap();
    int first_rise = -1;
    int second_rise = -1;
    int max_s = -1;
    int min_s = 2000;
    logic prev_irq = 1'b0;
    fcw = 8'h80; enable_irq = 1'b1; run = 1'b1;
    for (int i = 1; i <= 1100; i++) begin
      tick();
      checks++;
      if (data_valid !== exp_valid) begin
        errors++;
        $display("FAIL run_valid cyc %0d: got %0b expected %0b", i, data_valid, exp_valid);
      end
      checks++;
      if (data_sin !== 10'(exp_sin)) begin
        errors++;
        $display("FAIL run_sample cyc %0d: got %0d expected %0d", i, data_sin, exp_sin);
      end
      checks++;
      if (irq !== exp_irq) begin
        errors++;
        $display("FAIL run_irq cyc %0d: got %0b expected %0b", i, irq, exp_irq);
      end
      if (i == 2 || i == 3) begin
        checks++;
        if (data_valid !== (i == 3)) begin
          errors++;
          $display("FAIL valid_rise cyc %0d: got %0b expected %0b", i, data_valid, i == 3);
        end
      end
      if (data_valid) begin
        if (int'(data_sin) > max_s) max_s = int'(data_sin);
        if (int'(data_sin) < min_s) min_s = int'(data_sin);
      end
      if (irq && !prev_irq) begin
        if (first_rise < 0) first_rise = i;
        else if (second_rise < 0) second_rise = i;
      end
      prev_irq  = irq;
      clear_irq = irq;
    end
    clear_irq = 1'b0;
    checks++;
    if (first_rise != 513) begin
      errors++;
      $display("FAIL first_irq_cycle: got %0d expected 513", first_rise);
    end
    checks++;
    if (second_rise - first_rise != 512) begin
      errors++;
      $display("FAIL wrap_period: got %0d expected 512", second_rise - first_rise);
    end
    checks++;
    if (max_s != 1023 || min_s != 0) begin
      errors++;
      $display("FAIL sample_range: got max=%0d min=%0d expected 1023/0", max_s, min_s);
    end
  endtask

  task automatic test_irq_clear();
    int n;
    fcw = 8'h80; enable_irq = 1'b1; run = 1'b1; clear_irq = 1'b0;
    n = 0;
    while (!irq && n < 1200) begin tick(); n++; end
    checks++;
    if (!irq) begin
      errors++;
      $display("FAIL irq_wait: got irq=0 expected 1 within 1200 cycles");
    end
    n = 0;
    while (!m_wrap && n < 1200) begin tick(); n++; end
    clear_irq = 1'b1;
    tick();
    clear_irq = 1'b0;
    checks++;
    if (irq !== 1'b1 || irq !== exp_irq) begin
      errors++;
      $display("FAIL clear_vs_wrap: got irq=%0b expected 1", irq);
    end
    enable_irq = 1'b0;
    #1;
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_mask: got irq=%0b expected 0", irq);
    end
    enable_irq = 1'b1;
    #1;
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_unmask_retained: got irq=%0b expected 1", irq);
    end
    clear_irq = 1'b1;
    tick();
    clear_irq = 1'b0;
    checks++;
    if (irq !== 1'b0 || irq !== exp_irq) begin
      errors++;
      $display("FAIL clear_no_wrap: got irq=%0b expected 0", irq);
    end
  endtask

  task automatic test_masked_wraps();
    int n;
    fcw = 8'h01; enable_irq = 1'b0; run = 1'b1;
    clear_irq = 1'b1;
    tick();
    clear_irq = 1'b0;
    for (int i = 0; i < 65536; i++) begin
      tick();
      checks++;
      if (irq !== 1'b0) begin
        errors++;
        $display("FAIL masked_irq cyc %0d: got %0b expected 0", i, irq);
      end
      checks++;
      if (data_sin !== 10'(exp_sin)) begin
        errors++;
        $display("FAIL slow_sample cyc %0d: got %0d expected %0d", i, data_sin, exp_sin);
      end
    end
    enable_irq = 1'b1;
    #1;
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL dropped_wrap: got irq=%0b expected 0", irq);
    end
    fcw = 8'h80;
    n = 0;
    while (n < 600) begin
      tick();
      n++;
      checks++;
      if (irq !== exp_irq) begin
        errors++;
        $display("FAIL irq_after_enable cyc %0d: got %0b expected %0b", n, irq, exp_irq);
      end
      if (irq) break;
    end
    checks++;
    if (!irq) begin
      errors++;
      $display("FAIL irq_next_wrap: got irq=0 expected 1 within 600 cycles");
    end
    clear_irq = 1'b1;
    tick();
    clear_irq = 1'b0;
  endtask

  task automatic test_pause_resume();
    logic [9:0] frozen;
    fcw = 8'h80; enable_irq = 1'b0; run = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      checks++;
      if (data_sin !== 10'(exp_sin)) begin
        errors++;
        $display("FAIL pre_pause cyc %0d: got %0d expected %0d", i, data_sin, exp_sin);
      end
    end
    run = 1'b0;
    frozen = '0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      checks++;
      if (data_valid !== exp_valid || data_sin !== 10'(exp_sin)) begin
        errors++;
        $display("FAIL pause cyc %0d: got sin=%0d valid=%0b expected %0d/%0b",
                 i, data_sin, data_valid, exp_sin, exp_valid);
      end
      if (i == 2 || i == 3) begin
        checks++;
        if (data_valid !== (i == 2)) begin
          errors++;
          $display("FAIL valid_fall cyc %0d: got %0b expected %0b", i, data_valid, i == 2);
        end
      end
      if (i == 3) frozen = data_sin;
      if (i > 3) begin
        checks++;
        if (data_sin !== frozen) begin
          errors++;
          $display("FAIL frozen cyc %0d: got %0d expected %0d", i, data_sin, frozen);
        end
      end
    end
    run = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      checks++;
      if (data_valid !== exp_valid || data_sin !== 10'(exp_sin)) begin
        errors++;
        $display("FAIL resume cyc %0d: got sin=%0d valid=%0b expected %0d/%0b",
                 i, data_sin, data_valid, exp_sin, exp_valid);
      end
    end
  endtask

  task automatic test_async_reset();
    int n;
    fcw = 8'h80; enable_irq = 1'b1; run = 1'b1;
    n = 0;
    while (!irq && n < 600) begin tick(); n++; end
    checks++;
    if (!irq || !data_valid) begin
      errors++;
      $display("FAIL pre_reset_state: got irq=%0b valid=%0b expected 1/1", irq, data_valid);
    end
    #2;
    ResetN = 1'b0;
    #1;
    checks++;
    if (data_sin !== 10'h200 || data_valid !== 1'b0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got sin=%0d valid=%0b irq=%0b expected 512/0/0", data_sin, data_valid, irq);
    end
    model_reset();
    #3;
    ResetN = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      checks++;
      if (data_valid !== exp_valid || data_sin !== 10'(exp_sin) || irq !== exp_irq) begin
        errors++;
        $display("FAIL post_reset cyc %0d: got sin=%0d valid=%0b irq=%0b expected %0d/%0b/%0b",
                 i, data_sin, data_valid, irq, exp_sin, exp_valid, exp_irq);
      end
      if (i == 3) begin
        checks++;
        if (data_sin !== 10'd518 || data_valid !== 1'b1) begin
          errors++;
          $display("FAIL restart_first_sample: got sin=%0d valid=%0b expected 518/1", data_sin, data_valid);
        end
      end
    end
  endtask

  initial begin
    for (int a = 0; a < 64; a++) begin
      bench_lut[a] = $rtoi(511.0 * $sin(3.14159265358979323846 * real'(2 * a + 1) / 256.0) + 0.5);
    end
    test_reset();
    test_run_wrap();
    test_irq_clear();
    test_masked_wraps();
    test_pause_resume();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sine_wave_gen.md
Name: sine_wave_gen

Overview:
DDS sine generator core that sits directly downstream of the sine-wave CSR block.
- Consumes its run, fcw, enable_irq and clear_irq outputs.
- Produces the 10-bit sample the CSR reads back as data_sin, plus the wrap interrupt.
- Internals: phase accumulator, quarter-wave LUT with symmetry folding, 3-stage registered pipeline, sticky IRQ.

Parameters:
PHASE_W, 16, phase accumulator width (bits); minimum 2+LUT_ADDR_W.
LUT_ADDR_W, 6, quarter-wave LUT index width (64 entries).
OUT_W, 10, sample width, unsigned offset binary.

Ports:
Clk  input  1  system clock, all state on rising edge.
ResetN  input  1  asynchronous active-low reset.
run  input  1  1 = advance phase each cycle; 0 = hold phase.
fcw  input  8  frequency control word, zero-extended to PHASE_W.
enable_irq  input  1  interrupt enable/mask.
clear_irq  input  1  single-cycle clear strobe for the pending interrupt.
data_sin  output  OUT_W  current sine sample, offset binary (midscale 512).
data_valid  output  1  data_sin derived from a running phase.
irq  output  1  interrupt request, level, = pending & enable_irq.

Behaviour:
- Reset (async, ResetN=0):
  - phase=0, pipeline regs=0, data_sin=10'h200, data_valid=0, pending=0.
  - irq=0 follows from pending=0.
  - Reset mid-operation discards all in-flight samples immediately.
- Stage 1, phase:
  - If run: phase <= phase + {0,fcw}, modulo 2^PHASE_W.
  - wrap = carry out of that add, registered alongside the new phase.
  - If !run: phase holds, wrap=0.
  - fcw=0 with run=1: phase constant, never wraps.
  - fcw changes take effect on the next add; there is no glitch correction.
- Stage 2, LUT:
  - quad = phase[PHASE_W-1:PHASE_W-2].
  - idx = phase[PHASE_W-3 -: LUT_ADDR_W].
  - quad[0]=1: address = ~idx (mirror); otherwise address = idx.
  - Registered read of lut[address]; quad[1] is delayed one cycle with it.
- LUT contents, 9-bit magnitude: lut[i] = round(511*sin(2*pi*(i+0.5)/2^(LUT_ADDR_W+2))). For the defaults, lut[0]=6 and lut[63]=511.
- Stage 3, output:
  - quad[1]=0: data_sin <= 512 + lut.
  - quad[1]=1: data_sin <= 511 - lut.
  - Range 0..1023, no overflow, symmetric about 511.5.
- Latency: a phase value registered in cycle N appears on data_sin at the edge ending cycle N+2.
- data_valid: run delayed through a 3-bit shift register aligned with the pipeline.
  - Goes high 3 cycles after run rises, low 3 cycles after run falls.
  - data_sin holds its last value while run=0, since the phase holds.
- Interrupt:
  - pending set when wrap & enable_irq; cleared when clear_irq.
  - Set and clear in the same cycle: set wins, so no lost wrap.
  - Wraps while enable_irq=0 are dropped.
  - Deasserting enable_irq masks irq combinationally; pending is retained.
- Wrap period: exactly 2^PHASE_W / fcw cycles when fcw is a power of two; otherwise it jitters by one cycle.

Optional Feature:
SINE_PHASE_RESTART_EN
- Defined: a run 0->1 edge (registered run_d) loads phase with {0,fcw} instead of phase+fcw. Every burst starts at phase 0 plus one step, so the first valid sample is 518 for fcw=1, PHASE_W=16.
- Undefined: phase resumes from its held value on a run edge.

Decomposition:
- Shared package sine_pkg:
  - PHASE_W/LUT_ADDR_W/OUT_W defaults.
  - MIDSCALE=10'h200.
  - The quadrant encoding constants.
  - The function generating LUT entries.
- One natural sub-module, sine_lut_quarter: registered ROM taking address, returning the 9-bit magnitude, one-cycle read latency.
- The top holds the accumulator, fold/unfold logic, valid shifter and IRQ.

Test Plan:
1. Reset release, run=0 -> data_sin=512, data_valid=0 and irq=0 for 100 cycles.
2. fcw=8'h80, run=1, enable_irq=1:
   - data_valid rises on the 3rd edge after run.
   - Wrap every 512 cycles; irq rises one cycle after the wrap.
   - Over one period, data_sin max=1023 and min=0.
3. Pending irq; clear_irq pulsed on the same cycle as a new wrap -> irq stays 1. Pulsed on a non-wrap cycle -> irq=0 next cycle.
4. fcw=8'h01, run=1, enable_irq=0 for 65536 cycles -> irq never asserts. Set enable_irq=1 -> irq stays 0 until the next wrap.
5. run toggled 0 mid-waveform -> data_sin frozen at its last value, data_valid falls after 3 cycles. Resume -> the sequence continues from the held phase (SINE_PHASE_RESTART_EN undefined).
6. ResetN pulsed low mid-run -> asynchronously data_sin=512, data_valid=0, irq=0. Phase restarts from 0 after release.
